// File: rtl/rom_read_sequencer.sv
// Sequences flash CE/OE timing for GBA GamePak reads from synchronized CS/RD strobes.
// Define ROM_PREFETCH_EN to add a one-word sequential read-ahead buffer (PREFETCH state).
module rom_read_sequencer #(
   parameter int WAIT_CYCLES = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        GBA_CS,
   input  logic        GBA_RD,
   input  logic [23:0] ROM_A,
   input  logic [15:0] ROM_D,
   output logic        ROM_CE_N,
   output logic        ROM_OE_N,
   output logic [15:0] GBA_DOUT,
   output logic        GBA_DOE,
   output logic        BUSY,
   output logic        ABORT
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      DRIVE
`ifdef ROM_PREFETCH_EN
      , PREFETCH
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
   logic                   rd_prev_q, rd_prev_d;
   logic                   pend_q, pend_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [23:0]            addr_q, addr_d;
   logic [15:0]            dout_q, dout_d;
   logic                   ce_n_q, ce_n_d;
   logic                   oe_n_q, oe_n_d;
   logic                   doe_q, doe_d;
   logic                   busy_q, busy_d;
   logic                   abort_q, abort_d;
   logic                   cs_s, rd_s, req_edge, req;
`ifdef ROM_PREFETCH_EN
   logic                   pf_ph_q, pf_ph_d;
   logic                   pf_valid_q, pf_valid_d;
   logic [23:0]            pf_addr_q, pf_addr_d;
   logic [15:0]            pf_data_q, pf_data_d;
`endif

   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign rd_s     = rd_sync_q[SYNC_STAGES-1];
   assign req_edge = rd_prev_q & ~rd_s & ~cs_s;
   // A latched request survives until it is served or the cartridge is deselected.
   assign req      = ~cs_s & (req_edge | pend_q);

   always_comb begin
      cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], GBA_CS};
      rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], GBA_RD};
      rd_prev_d = rd_s;
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      abort_d   = 1'b0;
      pend_d    = (pend_q | (req_edge & (state_q != IDLE))) & ~cs_s;
`ifdef ROM_PREFETCH_EN
      pf_ph_d    = pf_ph_q;
      pf_valid_d = pf_valid_q & ~cs_s;
      pf_addr_d  = pf_addr_q;
      pf_data_d  = pf_data_q;
`endif

      case (state_q)
         IDLE: begin
            if (req) begin
               pend_d = 1'b0;
               addr_d = ROM_A;
`ifdef ROM_PREFETCH_EN
               if (pf_valid_q && (ROM_A == pf_addr_q)) begin
                  dout_d  = pf_data_q;
                  state_d = DRIVE;
               end else begin
                  pf_valid_d = 1'b0;
                  state_d    = SETUP;
               end
`else
               state_d = SETUP;
`endif
            end
         end
         SETUP: begin
            if (rd_s || cs_s) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else begin
               state_d = ACCESS;
               cnt_d   = WAIT_LD;
            end
         end
         ACCESS: begin
            // Strobe release wins over a capture falling in the same cycle.
            if (rd_s || cs_s) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (cnt_q == 4'd0) begin
               dout_d  = ROM_D;
               state_d = DRIVE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DRIVE: begin
            if (rd_s || cs_s) begin
`ifdef ROM_PREFETCH_EN
               if (!cs_s) begin
                  state_d    = PREFETCH;
                  pf_ph_d    = 1'b0;
                  pf_valid_d = 1'b0;
                  addr_d     = addr_q + 24'd1;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
         end
`ifdef ROM_PREFETCH_EN
         PREFETCH: begin
            if (cs_s) begin
               state_d = IDLE;
               pf_ph_d = 1'b0;
            end else if (req) begin
               pend_d  = 1'b0;
               addr_d  = ROM_A;
               pf_ph_d = 1'b0;
               state_d = SETUP;
            end else if (!pf_ph_q) begin
               pf_ph_d = 1'b1;
               cnt_d   = WAIT_LD;
            end else if (cnt_q == 4'd0) begin
               pf_data_d  = ROM_D;
               pf_addr_d  = addr_q;
               pf_valid_d = 1'b1;
               pf_ph_d    = 1'b0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      ce_n_d = (state_d == IDLE);
      busy_d = (state_d != IDLE);
      doe_d  = (state_d == DRIVE);
`ifdef ROM_PREFETCH_EN
      oe_n_d = ~((state_d == ACCESS) || ((state_d == PREFETCH) && pf_ph_d));
`else
      oe_n_d = ~(state_d == ACCESS);
`endif
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         cs_sync_q  <= '1;
         rd_sync_q  <= '1;
         rd_prev_q  <= 1'b1;
         pend_q     <= 1'b0;
         cnt_q      <= 4'd0;
         addr_q     <= 24'd0;
         dout_q     <= 16'h0000;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         doe_q      <= 1'b0;
         busy_q     <= 1'b0;
         abort_q    <= 1'b0;
`ifdef ROM_PREFETCH_EN
         pf_ph_q    <= 1'b0;
         pf_valid_q <= 1'b0;
         pf_addr_q  <= 24'd0;
         pf_data_q  <= 16'h0000;
`endif
      end else begin
         state_q    <= state_d;
         cs_sync_q  <= cs_sync_d;
         rd_sync_q  <= rd_sync_d;
         rd_prev_q  <= rd_prev_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         doe_q      <= doe_d;
         busy_q     <= busy_d;
         abort_q    <= abort_d;
`ifdef ROM_PREFETCH_EN
         pf_ph_q    <= pf_ph_d;
         pf_valid_q <= pf_valid_d;
         pf_addr_q  <= pf_addr_d;
         pf_data_q  <= pf_data_d;
`endif
      end
   end

   assign ROM_CE_N = ce_n_q;
   assign ROM_OE_N = oe_n_q;
   assign GBA_DOUT = dout_q;
   assign GBA_DOE  = doe_q;
   assign BUSY     = busy_q;
   assign ABORT    = abort_q;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Bench for rom_read_sequencer: cycle-offset timeline model relative to request cycle T.
module tb_rom_read_sequencer;
   localparam int W = 4;
   localparam int S = 2;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        GBA_CS;
   logic        GBA_RD;
   logic [23:0] ROM_A;
   logic [15:0] ROM_D;
   logic        ROM_CE_N;
   logic        ROM_OE_N;
   logic [15:0] GBA_DOUT;
   logic        GBA_DOE;
   logic        BUSY;
   logic        ABORT;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] last_dout = 16'h0000;

   always #5 CLK = ~CLK;

   rom_read_sequencer #(.WAIT_CYCLES(W), .SYNC_STAGES(S)) dut (
      .CLK(CLK), .RST_N(RST_N), .GBA_CS(GBA_CS), .GBA_RD(GBA_RD),
      .ROM_A(ROM_A), .ROM_D(ROM_D), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N),
      .GBA_DOUT(GBA_DOUT), .GBA_DOE(GBA_DOE), .BUSY(BUSY), .ABORT(ABORT)
   );

   // Control vector order: {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}
   task automatic test_reset();
      RST_N = 1'b0; GBA_CS = 1'b1; GBA_RD = 1'b1; ROM_A = 24'd0; ROM_D = 16'd0;
      repeat (2) @(negedge CLK);
      checks++;
      if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT} !== 5'b11000) begin
         failures++; $display("FAIL reset_ctl got=%b exp=%b", {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, 5'b11000);
      end
      checks++;
      if (GBA_DOUT !== 16'h0000) begin
         failures++; $display("FAIL reset_dout got=%h exp=0000", GBA_DOUT);
      end
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT} !== 5'b11000) begin
         failures++; $display("FAIL post_reset_idle got=%b exp=%b", {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, 5'b11000);
      end
      last_dout = 16'h0000;
   endtask

   // Caller sits on a negedge; the request pins fall here and T is S negedges later.
   task automatic run_read(input logic [23:0] addr, input bit hit, input bit rnd_d,
                           input logic [15:0] dat, input bit from_pf);
      logic [15:0] cap;
      logic [4:0]  exp_c;
      logic [15:0] exp_d;
      cap = dat;
      GBA_CS = 1'b0; ROM_A = addr; GBA_RD = 1'b0;
      ROM_D = rnd_d ? 16'($urandom) : dat;
      repeat (S) @(negedge CLK);
      for (int k = 0; k <= W + 3; k++) begin
         if (hit) begin
            exp_c = {!(k >= 1), 1'b1, (k >= 1), (k >= 1), 1'b0};
            exp_d = (k >= 1) ? dat : last_dout;
         end else begin
            exp_c = {!(k >= 1), !(k >= 2 && k <= W + 1), (k >= W + 2), (k >= 1), 1'b0};
            exp_d = (k >= W + 2) ? cap : last_dout;
         end
         if (!(from_pf && k == 0)) begin
            checks++;
            if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT} !== exp_c) begin
               failures++;
               $display("FAIL read_ctl addr=%h hit=%0d k=%0d got=%b exp=%b", addr, hit, k,
                        {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, exp_c);
            end
         end
         checks++;
         if (GBA_DOUT !== exp_d) begin
            failures++; $display("FAIL read_dout addr=%h k=%0d got=%h exp=%h", addr, k, GBA_DOUT, exp_d);
         end
         if (rnd_d) ROM_D = 16'($urandom);
         if (k == W + 1) cap = ROM_D;
         @(negedge CLK);
      end
      last_dout = hit ? dat : cap;
   endtask

   // Ends the DRIVE phase; with keep_cs the prefetch build runs a read-ahead of pf_val.
   task automatic release_rd(input bit keep_cs, input logic [15:0] pf_val);
      logic [4:0] exp_c;
      bit         pf;
`ifdef ROM_PREFETCH_EN
      pf = keep_cs;
`else
      pf = 1'b0;
`endif
      GBA_RD = 1'b1;
      if (!keep_cs) GBA_CS = 1'b1;
      ROM_D = pf_val;
      for (int j = 1; j <= S + 1; j++) begin
         @(negedge CLK);
         if (j <= S) exp_c = 5'b01110;
         else        exp_c = pf ? 5'b01010 : 5'b11000;
         checks++;
         if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT} !== exp_c) begin
            failures++; $display("FAIL release_ctl j=%0d got=%b exp=%b", j, {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, exp_c);
         end
      end
      if (pf) begin
         for (int j = 1; j <= W + 1; j++) begin
            @(negedge CLK);
            exp_c = (j <= W) ? 5'b00010 : 5'b11000;
            checks++;
            if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT} !== exp_c) begin
               failures++; $display("FAIL prefetch_ctl j=%0d got=%b exp=%b", j, {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, exp_c);
            end
            checks++;
            if (GBA_DOUT !== last_dout) begin
               failures++; $display("FAIL prefetch_dout j=%0d got=%h exp=%h", j, GBA_DOUT, last_dout);
            end
         end
      end
   endtask

   task automatic test_normal_read();
      run_read(24'h000100, 1'b0, 1'b0, 16'hBEEF, 1'b0);
      release_rd(1'b0, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         run_read(24'($urandom), 1'b0, 1'b1, 16'h0000, 1'b0);
         release_rd(1'b0, 16'h0000);
         repeat (int'($urandom_range(0, 3))) @(negedge CLK);
      end
   endtask

   // Raise RD at offset r from T; rd_s is seen high at T+r+S, which must fall in SETUP/ACCESS.
   task automatic test_abort();
      logic [4:0] exp_c;
      int         a;
      int         k;
      for (int r = -1; r <= W + 1 - S; r++) begin
         a = r + S;
         GBA_CS = 1'b0; GBA_RD = 1'b0; ROM_A = 24'($urandom); ROM_D = 16'($urandom);
         for (int n = 1; n <= S + W + 4; n++) begin
            @(negedge CLK);
            k = n - S;
            if (k >= 0) begin
               exp_c = {!(k >= 1 && k <= a), !(k >= 2 && k <= a), 1'b0, (k >= 1 && k <= a), (k == a + 1)};
               checks++;
               if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT} !== exp_c) begin
                  failures++; $display("FAIL abort_ctl r=%0d k=%0d got=%b exp=%b", r, k, {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, exp_c);
               end
               checks++;
               if (GBA_DOUT !== last_dout) begin
                  failures++; $display("FAIL abort_dout r=%0d k=%0d got=%h exp=%h", r, k, GBA_DOUT, last_dout);
               end
            end
            ROM_D = 16'($urandom);
            if (n == S + r) GBA_RD = 1'b1;
         end
         GBA_CS = 1'b1;
         repeat (S + 2) @(negedge CLK);
      end
   endtask

   task automatic test_reset_mid();
      GBA_CS = 1'b0; GBA_RD = 1'b0; ROM_A = 24'($urandom); ROM_D = 16'($urandom);
      repeat (S + 4) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      checks++;
      if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT} !== 5'b11000) begin
         failures++; $display("FAIL midreset_ctl got=%b exp=%b", {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, 5'b11000);
      end
      checks++;
      if (GBA_DOUT !== 16'h0000) begin
         failures++; $display("FAIL midreset_dout got=%h exp=0000", GBA_DOUT);
      end
      GBA_CS = 1'b1; GBA_RD = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge CLK);
         checks++;
         if (ABORT !== 1'b0) begin
            failures++; $display("FAIL midreset_abort j=%0d got=%b exp=0", j, ABORT);
         end
      end
      RST_N = 1'b1;
      last_dout = 16'h0000;
      for (int j = 0; j < W + 3; j++) begin
         @(negedge CLK);
         checks++;
         if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT, GBA_DOUT} !== {5'b11000, 16'h0000}) begin
            failures++; $display("FAIL midreset_after j=%0d got=%b/%h exp=11000/0000", j, {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, GBA_DOUT);
         end
      end
   endtask

   task automatic test_cs_release();
      logic [4:0] exp_c;
      run_read(24'($urandom), 1'b0, 1'b1, 16'h0000, 1'b0);
      GBA_CS = 1'b1;
      for (int j = 1; j <= S + 1; j++) begin
         @(negedge CLK);
         exp_c = (j <= S) ? 5'b01110 : 5'b11000;
         checks++;
         if ({ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT} !== exp_c) begin
            failures++; $display("FAIL cs_release j=%0d got=%b exp=%b", j, {ROM_CE_N, ROM_OE_N, GBA_DOE, BUSY, ABORT}, exp_c);
         end
      end
      GBA_RD = 1'b1;
      repeat (S + 2) @(negedge CLK);
   endtask

   // Sequential addresses with CS held low: read-ahead hits when prefetch is built in.
   task automatic test_back_to_back();
      logic [23:0] base;
      logic [15:0] pfv;
      bit          hit;
`ifdef ROM_PREFETCH_EN
      hit = 1'b1;
`else
      hit = 1'b0;
`endif
      base = 24'($urandom_range(0, 24'h7FFFFF));
      pfv  = 16'($urandom);
      run_read(base, 1'b0, 1'b1, 16'h0000, 1'b0);
      release_rd(1'b1, pfv);
      for (int i = 1; i <= 3; i++) begin
         run_read(base + 24'(i), hit, 1'b1, pfv, 1'b0);
         pfv = 16'($urandom);
         release_rd(1'b1, pfv);
      end
      GBA_CS = 1'b1;
      repeat (S + 2) @(negedge CLK);
   endtask

`ifdef ROM_PREFETCH_EN
   task automatic test_prefetch();
      logic [15:0] pfv;
      pfv = 16'($urandom);
      run_read(24'hFFFFFF, 1'b0, 1'b1, 16'h0000, 1'b0);
      release_rd(1'b1, pfv);
      run_read(24'h000000, 1'b1, 1'b1, pfv, 1'b0);
      release_rd(1'b1, 16'($urandom));
      run_read(24'h000200, 1'b0, 1'b1, 16'h0000, 1'b0);
      GBA_RD = 1'b1;
      repeat (2) @(negedge CLK);
      run_read(24'($urandom), 1'b0, 1'b1, 16'h0000, 1'b1);
      release_rd(1'b0, 16'h0000);
      repeat (2) @(negedge CLK);
   endtask
`endif

   initial begin
      test_reset();
      test_normal_read();
      test_abort();
      test_reset_mid();
      test_cs_release();
      test_back_to_back();
`ifdef ROM_PREFETCH_EN
      test_prefetch();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
